ysyx_24110015_dmem_resp: RTL and testbench
==========================================

Name: ysyx_24110015_dmem_resp

Overview:
- Data-memory responder: the slave end of the load/store request interface that the EXU/LSU drives.
- Accepts one word-wide read or byte-masked write request at a time over a valid/ready handshake.
- Holds a local synthesizable word array and returns read data or write acknowledgement after a programmable latency, over a second valid/ready channel.
- Replaces the DPI pmem path for synthesizable and multi-cycle-memory builds.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two.
- LATENCY, 1, cycles from request acceptance to rsp_valid; must be >=1 (elaboration-time check).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  initiator has a request
- req_ready  out  1  responder can accept a request
- req_wen  in  1  1=write, 0=read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data, already lane-aligned by the initiator
- req_wmask  in  4  byte enables; bit i enables wdata[8i+7:8i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator takes the response
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  address out of range

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous and active-high.
- States: IDLE, WAIT, RESP.
- Reset:
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready=0 while rst=1.
  - Memory contents are not cleared.
  - Reset mid-WAIT or mid-RESP abandons the transaction. A write already committed at acceptance stays committed.
- req_ready = (state==IDLE) && !rst, combinational. One outstanding transaction only.
- Acceptance: req_valid && req_ready at edge T. Latch wen, index, wdata, wmask, and the range flag.
- Index = (req_addr - ADDR_BASE) >> 2.
- Range check: in range iff ADDR_BASE <= req_addr < ADDR_BASE + 4*DEPTH_WORDS. Compute in 33 bits so there is no wrap at 32'hFFFF_FFFF.
- Writes are committed at the acceptance edge T, only if in range. Only the bytes enabled by wmask change; wmask=0 changes nothing but still responds.
- Transitions:
  - LATENCY==1: IDLE goes to RESP at T, so rsp_valid is high in cycle T+1.
  - LATENCY>1: IDLE goes to WAIT at T with counter=LATENCY-1. WAIT decrements the counter each cycle. When counter==1, go to RESP. rsp_valid rises exactly LATENCY cycles after acceptance.
  - On entering RESP, capture:
    - rsp_rdata = read && in range ? array[index] : 0. The value reflects all prior writes, including a write accepted immediately before.
    - rsp_err = !in_range.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid. rsp_rdata and rsp_err keep their last values; they are don't-care while rsp_valid=0.
- rsp_ready held high in RESP: the handshake completes in the first RESP cycle.
- Back-to-back: a new request can be accepted the cycle after the response handshake. Peak rate is one transaction per LATENCY+1 cycles.
- req_valid with req_ready=0 is ignored; the initiator must hold the request.
- A request that changes while unaccepted is not a protocol violation for the responder.
- Out-of-range write: no array change; rsp_err=1.

Decomposition:
- Shared header (macros.v / common package):
  - state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - default ADDR_BASE (32'h8000_0000);
  - byte-lane mask width constant.
- One sub-module: ysyx_24110015_sram_array.
  - Synchronous write with a 4-bit byte mask.
  - Combinational read by index.
  - Parameter DEPTH_WORDS.
- The FSM, counter and range check stay in the top.

Test Plan:
- Reset then write/read: after rst, write 0x8000_0010 data 0xDEADBEEF mask 4'hF, then read 0x8000_0010 -> read rsp_rdata=0xDEADBEEF, rsp_err=0. LATENCY=1: rsp_valid exactly 1 cycle after each acceptance.
- Byte mask: word at 0x8000_0020 holds 0x11223344; write wdata 0xAABBCCDD mask 4'b0101; read -> 0x11BB33DD.
- Latency and backpressure: LATENCY=4; read accepted at cycle 10 -> rsp_valid at cycle 14. Hold rsp_ready=0 for 3 cycles -> rsp_rdata stable, req_ready=0 throughout. rsp_ready=1 at cycle 17 -> req_ready=1 at cycle 18.
- Range error:
  - read 0x7FFF_FFFC -> rsp_err=1, rsp_rdata=0.
  - write 0x8000_4000 (DEPTH 4096) -> rsp_err=1; word 0 unchanged.
  - read 0x8000_3FFC -> rsp_err=0.
- Reset mid-operation: LATENCY=3; accept write 0x8000_0000 data 0x5 at cycle T; assert rst at T+1 -> rsp_valid never rises, req_ready=0 during rst. Read afterwards -> 0x5 (write committed).
- Back-to-back with ignored request: req_valid held high continuously with alternating write/read to the same address. Each request accepted only in IDLE; every read returns the immediately preceding write's data.

Source files
------------

// File: rtl/ysyx_24110015_dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, default base address and byte-lane helpers.
package ysyx_24110015_dmem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
  localparam int MASK_W = 4;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0]       old_w,
    input logic [31:0]       new_w,
    input logic [MASK_W-1:0] mask
  );
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < MASK_W; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_24110015_sram_array.sv
// Word array with byte-masked synchronous write.
// Read is combinational by index.
module ysyx_24110015_sram_array
  import ysyx_24110015_dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [31:0]       i_wdata,
  input  logic [MASK_W-1:0] i_wmask,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // commit enabled byte lanes on the write edge
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= merge_bytes(r_mem[i_widx], i_wdata, i_wmask);
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ysyx_24110015_dmem_resp.sv
// Data-memory responder: one outstanding request,
// response after LATENCY cycles over valid/ready.
module ysyx_24110015_dmem_resp
  import ysyx_24110015_dmem_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  if (LATENCY < 1) begin : g_bad_lat
    $error("LATENCY must be >= 1");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wen;
  logic             r_inr;
  logic [IDX_W-1:0] r_idx;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic [32:0]      w_off;
  logic             w_inr;
  logic [IDX_W-1:0] w_idx;
  logic             w_acc;
  logic             w_we;
  logic [IDX_W-1:0] w_ridx;
  logic [31:0]      w_rd;

  // 33-bit offset so the top of the address space cannot wrap
  assign w_off = {1'b0, req_addr} - {1'b0, ADDR_BASE};
  assign w_inr = (req_addr >= ADDR_BASE) && (w_off < SPAN);
  assign w_idx = w_off[IDX_W+1:2];

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_acc     = req_valid && req_ready;
  assign w_we      = w_acc && req_wen && w_inr;

  // single-cycle latency reads the live request index
  assign w_ridx = (r_state == ST_IDLE) ? w_idx : r_idx;

  ysyx_24110015_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wdata (req_wdata),
    .i_wmask (req_wmask),
    .i_ridx  (w_ridx),
    .o_rdata (w_rd)
  );

  // request/latency/response state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wen       <= 1'b0;
      r_inr       <= 1'b0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_wen <= req_wen;
            r_inr <= w_inr;
            r_idx <= w_idx;
            if (LATENCY == 1) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= (!req_wen && w_inr) ? w_rd : '0;
              r_rsp_err   <= !w_inr;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!r_wen && r_inr) ? w_rd : '0;
            r_rsp_err   <= !r_inr;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_24110015_dmem_resp.sv
// Directed bench for the data-memory responder.
// Three instances: LATENCY 1, 4 and 3.
module tb_ysyx_24110015_dmem_resp;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_24110015_dmem_resp #(
      .LATENCY (g == 0 ? 1 : (g == 1 ? 4 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input int          d,
    input logic        wen,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    req_wen[d]   = wen;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wmask[d] = m;
  endtask

  task automatic xact(
    input  int          d,
    input  logic        wen,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  m,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n;
    @(negedge clk);
    drive(d, wen, a, wd, m);
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) check("acc_timeout", 32'(req_ready[d]), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] hold;
  logic [31:0] expq [$];
  logic [31:0] last_wd;
  int          bi;
  int          nresp;
  logic        pend;
  logic        ovl;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      drive(k, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    check("rst_rsp_rdata", rsp_rdata[0], 0);
    check("rst_rsp_err",   32'(rsp_err[0]), 0);
    check("rst_valid_l4",  32'(rsp_valid[1]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // basic write then read, latency 1
    xact(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("wr_lat", lat, 1);
    check("wr_err", 32'(er), 0);
    check("wr_rdata", rd, 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    check("rd_lat", lat, 1);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", 32'(er), 0);

    // zero mask still responds, changes nothing
    xact(0, 1, 32'h8000_0010, 32'h1234_5678, 4'h0, rd, er, lat);
    check("m0_lat", lat, 1);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    check("m0_data", rd, 32'hDEAD_BEEF);

    // byte mask merge
    xact(0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
    xact(0, 1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    xact(0, 0, 32'h8000_0022, 32'h0, 4'h0, rd, er, lat);
    check("mask_data", rd, 32'h11BB_33DD);

    // range checks
    xact(0, 1, 32'h8000_0000, 32'h0BAD_CAFE, 4'hF, rd, er, lat);
    xact(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
    check("lo_err", 32'(er), 1);
    check("lo_rdata", rd, 0);
    xact(0, 1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("hi_wr_err", 32'(er), 1);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    check("w0_kept", rd, 32'h0BAD_CAFE);
    check("w0_err", 32'(er), 0);
    xact(0, 0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat);
    check("top_err", 32'(er), 0);
    xact(0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, er, lat);
    check("wrap_err", 32'(er), 1);
    check("wrap_rdata", rd, 0);

    // latency 4 with response backpressure
    xact(1, 1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    check("l4_wr_lat", lat, 4);
    @(negedge clk);
    drive(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    check("bp_rdy", 32'(req_ready[1]), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!rsp_valid[1] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("l4_rd_lat", lat, 4);
    check("l4_rd_data", rsp_rdata[1], 32'hCAFE_F00D);
    hold = rsp_rdata[1];
    for (int k = 0; k < 3; k++) begin
      check("bp_stable", rsp_rdata[1], hold);
      check("bp_valid", 32'(rsp_valid[1]), 1);
      check("bp_req_rdy", 32'(req_ready[1]), 0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_done_rdy", 32'(req_ready[1]), 1);
    check("bp_done_vld", 32'(rsp_valid[1]), 0);

    // reset while a latency-3 write is in flight
    @(negedge clk);
    drive(2, 1'b1, 32'h8000_0000, 32'h0000_0005, 4'hF);
    req_valid[2] = 1'b1;
    check("mr_rdy", 32'(req_ready[2]), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_rdy_rst", 32'(req_ready[2]), 0);
      check("mr_vld_rst", 32'(rsp_valid[2]), 0);
    end
    rst[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mr_vld_after", 32'(rsp_valid[2]), 0);
    end
    xact(2, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    check("mr_lat", lat, 3);
    check("mr_data", rd, 32'h0000_0005);

    // back-to-back alternating write/read, valid held high
    bi = 0;
    nresp = 0;
    pend = 1'b0;
    ovl = 1'b0;
    last_wd = 32'h0;
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    drive(0, 1'b1, 32'h8000_0100, 32'hC0DE_0000, 4'hF);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 200 && nresp < 8; c++) begin
      if (rsp_valid[0]) begin
        if (req_ready[0]) ovl = 1'b1;
        if (expq.size() == 0) begin
          check("b2b_extra", 32'(nresp), 8);
        end else begin
          check("b2b_rdata", rsp_rdata[0], expq.pop_front());
          check("b2b_err", 32'(rsp_err[0]), 0);
        end
        nresp++;
      end
      if (pend) begin
        pend = 1'b0;
        bi++;
        if (bi < 8) begin
          drive(0, (bi % 2) == 0, 32'h8000_0100,
                32'hC0DE_0000 ^ (32'(bi) * 32'h1111), 4'hF);
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      if (req_valid[0] && req_ready[0]) begin
        pend = 1'b1;
        if (req_wen[0]) begin
          last_wd = req_wdata[0];
          expq.push_back(32'h0);
        end else begin
          expq.push_back(last_wd);
        end
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check("b2b_count", 32'(nresp), 8);
    check("b2b_overlap", 32'(ovl), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
